// File: rtl/pkt_counter_bank.sv
// Per-channel activity counters with a one-cycle registered read port.
// Counters wrap or saturate, keep sticky overflow flags, and may clear on read.
module pkt_counter_bank #(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 10,
  parameter int CNT_W       = 5,
  parameter bit SAT_MODE    = 1'b0,
  parameter bit CLR_ON_READ = 1'b0,
  localparam int IDX_W      = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             state,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic                   req,
  input  logic [IDX_W-1:0]       idx,
  output logic                   valid,
  output logic [CNT_W-1:0]       data_out,
  output logic [N_CH-1:0]        ovf
);

  localparam logic [3:0]       ST_RESET = 4'b0001;
  localparam logic [3:0]       ST_IDLE  = 4'b0100;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W:0]   N_CH_EXT = (IDX_W+1)'(N_CH);

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] data_out_q, data_out_d;

  logic [N_CH-1:0]  act;
  logic             soft_clr;
  logic             rd_acc;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      act[k] = |data_in[k*DATA_W +: DATA_W];
    end
  end

  assign soft_clr = (state == ST_RESET);
  assign rd_acc   = req && (state == ST_IDLE) && ({1'b0, idx} < N_CH_EXT);

  always_comb begin
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    data_out_d = '0;
    if (soft_clr) begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_d[k] = '0;
      end
      ovf_d = '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (act[k]) begin
          if (cnt_q[k] == CNT_MAX) begin
            ovf_d[k] = 1'b1;
            cnt_d[k] = SAT_MODE ? CNT_MAX : '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
      end
      if (rd_acc) begin
        valid_d    = 1'b1;
        data_out_d = cnt_q[idx];
        // The restarted counter still sees this cycle's activity; its overflow is dropped.
        if (CLR_ON_READ) begin
          cnt_d[idx] = act[idx] ? CNT_W'(1) : '0;
          ovf_d[idx] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k] <= '0;
      end
      ovf_q      <= '0;
      valid_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_out_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_pkt_counter_bank.sv
// Bench for pkt_counter_bank: wrap, saturate and clear-on-read instances share stimulus.
// Expected read results are queued at drive time and compared after the edge.
module tb_pkt_counter_bank;

  localparam int N_CH = 4;
  localparam int DW   = 10;
  localparam int CW   = 5;
  localparam int NI   = 3;  // 0: wrap, 1: saturate, 2: clear-on-read

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       state;
  logic [N_CH*DW-1:0] data_in;
  logic             req;
  logic [1:0]       idx;

  logic [NI-1:0]    valid;
  logic [CW-1:0]    dout [NI];
  logic [N_CH-1:0]  ovf  [NI];

  always #5 clk = ~clk;

  pkt_counter_bank #(.N_CH(N_CH), .DATA_W(DW), .CNT_W(CW), .SAT_MODE(1'b0), .CLR_ON_READ(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .state(state), .data_in(data_in), .req(req), .idx(idx),
    .valid(valid[0]), .data_out(dout[0]), .ovf(ovf[0]));
  pkt_counter_bank #(.N_CH(N_CH), .DATA_W(DW), .CNT_W(CW), .SAT_MODE(1'b1), .CLR_ON_READ(1'b0)) u_sat (
    .clk(clk), .reset(reset), .state(state), .data_in(data_in), .req(req), .idx(idx),
    .valid(valid[1]), .data_out(dout[1]), .ovf(ovf[1]));
  pkt_counter_bank #(.N_CH(N_CH), .DATA_W(DW), .CNT_W(CW), .SAT_MODE(1'b0), .CLR_ON_READ(1'b1)) u_cor (
    .clk(clk), .reset(reset), .state(state), .data_in(data_in), .req(req), .idx(idx),
    .valid(valid[2]), .data_out(dout[2]), .ovf(ovf[2]));

  typedef struct {
    int v    [NI];
    int d    [NI];
    int o    [NI];
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt [NI][N_CH];
  bit   m_ovf [NI][N_CH];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N_CH*DW-1:0] word(input int ch, input logic [DW-1:0] val);
    logic [N_CH*DW-1:0] w;
    w = '0;
    w[ch*DW +: DW] = val;
    return w;
  endfunction

  // Reference behaviour: a read returns the pre-edge count; the counters then advance.
  task automatic model_step(output exp_t e);
    bit act [N_CH];
    bit rd;
    for (int k = 0; k < N_CH; k++) act[k] = (data_in[k*DW +: DW] != 0);
    rd = !reset && (state == 4'b0100) && req;
    for (int i = 0; i < NI; i++) begin
      e.v[i] = rd ? 1 : 0;
      e.d[i] = rd ? m_cnt[i][idx] : 0;
      if (reset || state == 4'b0001) begin
        for (int k = 0; k < N_CH; k++) begin
          m_cnt[i][k] = 0;
          m_ovf[i][k] = 0;
        end
      end else begin
        for (int k = 0; k < N_CH; k++) begin
          if (act[k]) begin
            if (m_cnt[i][k] + 1 >= (1 << CW)) begin
              m_ovf[i][k] = 1;
              m_cnt[i][k] = (i == 1) ? (1 << CW) - 1 : 0;
            end else begin
              m_cnt[i][k] = m_cnt[i][k] + 1;
            end
          end
        end
        if (rd && i == 2) begin
          m_cnt[i][idx] = act[idx] ? 1 : 0;
          m_ovf[i][idx] = 0;
        end
      end
      e.o[i] = 0;
      for (int k = 0; k < N_CH; k++) e.o[i] |= (int'(m_ovf[i][k]) << k);
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] st, input logic [N_CH*DW-1:0] d,
                       input logic rq, input logic [1:0] ix);
    exp_t e;
    reset   = r;
    state   = st;
    data_in = d;
    req     = rq;
    idx     = ix;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("valid[%0d]", i), int'(valid[i]), e.v[i]);
      chk($sformatf("data_out[%0d]", i), int'(dout[i]), e.d[i]);
      chk($sformatf("ovf[%0d]", i), int'(ovf[i]), e.o[i]);
    end
  endtask

  localparam logic [3:0] RST  = 4'b0001;
  localparam logic [3:0] IDLE = 4'b0100;
  localparam logic [3:0] BUSY = 4'b0010;

  initial begin
    logic [N_CH*DW-1:0] all_act;
    all_act = word(0, 10'h1) | word(1, 10'h200) | word(2, 10'h3) | word(3, 10'h55);
    reset = 1'b1; state = IDLE; data_in = '0; req = 1'b0; idx = '0;

    // reset with activity present
    cycle(1, IDLE, all_act, 1, 2);
    cycle(1, IDLE, all_act, 1, 2);
    for (int i = 0; i < NI; i++) begin
      chk("rst_valid", int'(valid[i]), 0);
      chk("rst_ovf", int'(ovf[i]), 0);
    end

    // ch2 counts seven cycles, then read ch2 and ch0
    repeat (7) cycle(0, IDLE, word(2, 10'h3), 0, 0);
    cycle(0, IDLE, '0, 1, 2);
    chk("t2_ch2", int'(dout[0]), 7);
    chk("t2_ch2_valid", int'(valid[0]), 1);
    cycle(0, IDLE, '0, 1, 0);
    chk("t2_ch0", int'(dout[0]), 0);

    // no accept outside IDLE; soft clear mid-count
    cycle(0, BUSY, word(1, 10'h1), 1, 0);
    chk("t4_busy_valid", int'(valid[0]), 0);
    repeat (3) cycle(0, BUSY, all_act, 0, 0);
    cycle(0, RST, all_act, 1, 1);
    chk("t4_softclr_valid", int'(valid[0]), 0);
    for (int k = 0; k < N_CH; k++) begin
      cycle(0, IDLE, '0, 1, 2'(k));
      chk("t4_after_clr", int'(dout[0]), 0);
    end

    // overflow: 33 active cycles on ch1
    cycle(1, IDLE, '0, 0, 0);
    repeat (33) cycle(0, IDLE, word(1, 10'h80), 0, 0);
    cycle(0, IDLE, '0, 1, 1);
    chk("t3_wrap", int'(dout[0]), 1);
    chk("t3_sat", int'(dout[1]), 31);
    chk("t3_ovf_wrap", int'(ovf[0][1]), 1);
    chk("t3_ovf_sat", int'(ovf[1][1]), 1);

    // clear-on-read: ch3 wraps to 5 with ovf set, stays active through two reads
    cycle(1, IDLE, '0, 0, 0);
    repeat (37) cycle(0, IDLE, word(3, 10'h2), 0, 0);
    chk("t5_ovf_pre", int'(ovf[2][3]), 1);
    cycle(0, IDLE, word(3, 10'h2), 1, 3);
    chk("t5_first", int'(dout[2]), 5);
    chk("t5_ovf_clr", int'(ovf[2][3]), 0);
    cycle(0, IDLE, word(3, 10'h2), 1, 3);
    chk("t5_second", int'(dout[2]), 1);
    chk("t5_wrap_second", int'(dout[0]), 6);

    // back-to-back reads with all channels active
    cycle(1, IDLE, '0, 0, 0);
    repeat (3) cycle(0, IDLE, all_act, 0, 0);
    for (int k = 0; k < N_CH; k++) begin
      cycle(0, IDLE, all_act, 1, 2'(k));
      chk("t6_valid", int'(valid[0]), 1);
      chk("t6_data", int'(dout[0]), 3 + k);
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [N_CH*DW-1:0] d;
      logic [3:0] st;
      int sel;
      d = '0;
      for (int k = 0; k < N_CH; k++)
        if ($urandom_range(0, 3) != 0) d[k*DW +: DW] = DW'($urandom_range(1, 1023));
      sel = $urandom_range(0, 19);
      st = (sel == 0) ? RST : (sel < 4) ? BUSY : (sel == 4) ? 4'b0000 : IDLE;
      cycle(($urandom_range(0, 99) == 0), st, d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
